fifo_write_arbiter: RTL and testbench

- Shares the write port of one 8-bit `fifo` instance among NUM_REQ producers.
- Round-robin arbitration with burst locking: a winner keeps the port for up to MAX_BURST consecutive writes while it keeps requesting.
- Writes are suppressed while the FIFO reports full.
- Sits directly in front of the `fifo`: drives its write control and data, and samples its full flag.

---
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bus of the FIFO write arbiter: per-producer requests and bytes in,
// one-hot grant plus the FIFO write strobe/data out.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned OWNER_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   in_req;
    logic [NUM_REQ*8-1:0] in_req_data;
    logic                 in_fifo_is_full;
    logic [NUM_REQ-1:0]   out_gnt;
    logic                 out_fifo_write_ctrl;
    logic [7:0]           out_fifo_write_data;
    logic [OWNER_W-1:0]   out_owner;
    logic                 out_locked;

    modport master (
        output in_req, in_req_data, in_fifo_is_full,
        input  out_gnt, out_fifo_write_ctrl, out_fifo_write_data, out_owner, out_locked
    );

    modport slave (
        input  in_req, in_req_data, in_fifo_is_full,
        output out_gnt, out_fifo_write_ctrl, out_fifo_write_data, out_owner, out_locked
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking that shares one FIFO write port among
// NUM_REQ producers; grants are combinational so a byte is consumed in the cycle it is granted.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_write_arbiter_if.slave   bus
);
    localparam int unsigned OWNER_W = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0]    burst_cnt_q, burst_cnt_d;

    logic [OWNER_W-1:0]   win_idx;
    logic                 win_vld;
    logic [OWNER_W-1:0]   cand;
    int unsigned          pos;
    logic [BCNT_W-1:0]    cnt_inc;
    logic [NUM_REQ-1:0]   gnt;
    logic [7:0]           wdata;

    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] idx);
        return (idx == OWNER_W'(NUM_REQ - 1)) ? '0 : idx + OWNER_W'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping explicitly for non-power-of-2 counts
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = OWNER_W'(pos);
            if (!win_vld && bus.in_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        cnt_inc     = burst_cnt_q + BCNT_W'(1);
        case (state_q)
            IDLE: begin
                if (!bus.in_fifo_is_full && win_vld) begin
                    gnt[win_idx] = 1'b1;
                    burst_cnt_d  = BCNT_W'(1);
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = next_idx(win_idx);
                    end else begin
                        state_d = BURST;
                        owner_d = win_idx;
                    end
                end
            end
            BURST: begin
                if (bus.in_req[owner_q]) begin
                    // Full stalls the owner in place; nobody else may slip in
                    if (!bus.in_fifo_is_full) begin
                        gnt[owner_q] = 1'b1;
                        burst_cnt_d  = cnt_inc;
                        if (cnt_inc == BCNT_W'(MAX_BURST)) begin
                            state_d     = IDLE;
                            rr_ptr_d    = next_idx(owner_q);
                            burst_cnt_d = '0;
                        end
                    end
                end else begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_idx(owner_q);
                    burst_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) wdata = bus.in_req_data[8*i +: 8];
        end
    end

    // Reset blanks the outputs immediately, even between clock edges
    assign bus.out_gnt             = rst ? '0 : gnt;
    assign bus.out_fifo_write_ctrl = ~rst & (|gnt);
    assign bus.out_fifo_write_data = rst ? 8'h00 : wdata;
    assign bus.out_owner           = (!rst && state_q == BURST) ? owner_q : '0;
    assign bus.out_locked          = ~rst & (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations, then
// random requests against a tenure-level arbitration model and a FIFO model.
module tb_fifo_write_arbiter;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_write_arbiter_if #(.NUM_REQ(NR)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    int seen_pulses = 0;
    bit fifo_mode = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];

    // Model: current tenure holder (-1 none), writes in tenure, scan start
    int m_hold   = -1;
    int m_writes = 0;
    int m_next   = 0;

    always @(posedge rst) rst_pulses++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int start);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (start + k) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    logic [NR-1:0] c_req;
    logic          c_full;
    int            c_g;
    logic [NR-1:0] c_egnt;
    logic [7:0]    c_edata;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outs", 32'({bus.out_gnt, bus.out_fifo_write_ctrl, bus.out_fifo_write_data,
                                 bus.out_owner, bus.out_locked}), 32'd0);
            m_hold = -1; m_writes = 0; m_next = 0;
            seen_pulses = rst_pulses;
        end else begin
            if (seen_pulses != rst_pulses) begin
                m_hold = -1; m_writes = 0; m_next = 0;
                seen_pulses = rst_pulses;
            end
            c_req  = bus.in_req;
            c_full = bus.in_fifo_is_full;
            c_g    = -1;
            if (m_hold < 0) begin
                if (!c_full) c_g = pick(c_req, m_next);
            end else if (c_req[m_hold] && !c_full) begin
                c_g = m_hold;
            end
            c_egnt  = (c_g < 0) ? '0 : NR'(1) << c_g;
            c_edata = (c_g < 0) ? 8'h00 : bus.in_req_data[8*c_g +: 8];

            chk("gnt",    32'(bus.out_gnt), 32'(c_egnt));
            chk("wctrl",  32'(bus.out_fifo_write_ctrl), 32'(c_g >= 0));
            chk("wdata",  32'(bus.out_fifo_write_data), 32'(c_edata));
            chk("locked", 32'(bus.out_locked), 32'(m_hold >= 0));
            chk("owner",  32'(bus.out_owner), (m_hold >= 0) ? 32'(m_hold) : 32'd0);
            chk("onehot0", 32'($onehot0(bus.out_gnt)), 32'd1);
            chk("gnt_without_req", 32'(bus.out_gnt & ~c_req), 32'd0);
            chk("gnt_when_full", c_full ? 32'(bus.out_gnt) : 32'd0, 32'd0);
            if (fifo_mode && c_g >= 0) exp_q.push_back(c_edata);

            // Advance the model across the coming edge
            if (m_hold < 0) begin
                if (c_g >= 0) begin
                    m_writes = 1;
                    if (MB == 1) m_next = (c_g + 1) % NR;
                    else         m_hold = c_g;
                end
            end else if (!c_req[m_hold]) begin
                m_next = (m_hold + 1) % NR;
                m_hold = -1;
            end else if (!c_full) begin
                m_writes++;
                if (m_writes == MB) begin
                    m_next = (m_hold + 1) % NR;
                    m_hold = -1;
                end
            end
        end
    end

    task automatic step(input logic [NR-1:0] r, input logic f);
        @(posedge clk);
        #1;
        bus.in_req          = r;
        bus.in_fifo_is_full = f;
        bus.in_req_data     = $urandom;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_req = '0;
        bus.in_fifo_is_full = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int t2_ord[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    logic [NR-1:0] t3_gnt[12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
    logic          r_wr;
    logic [7:0]    r_wd;
    logic [7:0]    r_pop;

    initial begin
        bus.in_req = '0;
        bus.in_req_data = '0;
        bus.in_fifo_is_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single producer: continuous grants, lock drops for one re-grant cycle
        for (int c = 0; c < 8; c++) begin
            step(4'b0100, 1'b0);
            chk("t1_gnt", 32'(bus.out_gnt), 32'h4);
            chk("t1_locked", 32'(bus.out_locked), 32'((c % 4) != 0));
            chk("t1_data", 32'(bus.out_fifo_write_data), 32'(bus.in_req_data[23:16]));
        end

        do_reset();
        for (int c = 0; c < 17; c++) begin
            step(4'b1111, 1'b0);
            chk("t2_gnt", 32'(bus.out_gnt), 32'(1) << t2_ord[c]);
            chk("t2_wctrl", 32'(bus.out_fifo_write_ctrl), 32'd1);
        end

        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(4'b1111, (c >= 6 && c <= 8));
            chk("t3_gnt", 32'(bus.out_gnt), 32'(t3_gnt[c]));
            if (c >= 6 && c <= 8) chk("t3_owner", 32'(bus.out_owner), 32'd1);
        end

        do_reset();
        step(4'b0100, 1'b0);
        chk("t4a_first", 32'(bus.out_gnt), 32'h4);
        step(4'b1001, 1'b0);
        chk("t4a_bubble", 32'(bus.out_gnt), 32'h0);
        chk("t4a_bubble_locked", 32'(bus.out_locked), 32'd1);
        step(4'b1001, 1'b0);
        chk("t4a_next", 32'(bus.out_gnt), 32'h8);

        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0001, 1'b0);
        chk("t4b_bubble", 32'(bus.out_gnt), 32'h0);
        step(4'b0001, 1'b0);
        chk("t4b_next", 32'(bus.out_gnt), 32'h1);

        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        chk("t4c_drop_full", 32'(bus.out_gnt), 32'h0);
        step(4'b0100, 1'b0);
        chk("t4c_regrant", 32'(bus.out_gnt), 32'h4);
        chk("t4c_unlocked", 32'(bus.out_locked), 32'd0);

        // Asynchronous reset pulse in the middle of a burst
        do_reset();
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        chk("t5_locked_before", 32'(bus.out_locked), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_gnt_in_rst", 32'(bus.out_gnt), 32'h0);
        chk("t5_wctrl_in_rst", 32'(bus.out_fifo_write_ctrl), 32'd0);
        chk("t5_locked_in_rst", 32'(bus.out_locked), 32'd0);
        chk("t5_owner_in_rst", 32'(bus.out_owner), 32'd0);
        #1;
        rst = 1'b0;
        bus.in_req = 4'b1010;
        #1;
        chk("t5_first_after", 32'(bus.out_gnt), 32'h2);

        // Random requests with a FIFO model that drains at random
        do_reset();
        exp_q.delete();
        fifo_q.delete();
        fifo_mode = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r_wr = bus.out_fifo_write_ctrl;
            r_wd = bus.out_fifo_write_data;
            @(posedge clk);
            #1;
            if (($urandom_range(0, 1) == 1) && fifo_q.size() > 0) begin
                r_pop = fifo_q.pop_front();
                if (exp_q.size() == 0) chk("order_underflow", 32'd1, 32'd0);
                else chk("order", 32'(r_pop), 32'(exp_q.pop_front()));
            end
            if (r_wr) begin
                chk("overflow", 32'(fifo_q.size() < DEPTH), 32'd1);
                fifo_q.push_back(r_wd);
            end
            bus.in_fifo_is_full = (fifo_q.size() >= DEPTH);
            bus.in_req          = bus.in_req ^ (NR'($urandom) & NR'($urandom));
            bus.in_req_data     = $urandom;
        end
        fifo_mode = 1'b0;
        bus.in_req = '0;
        bus.in_fifo_is_full = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
